// File: rtl/execute_cycle_if.sv
// execute_cycle_if: bundles the ID/EX inputs, the forwarding sources, the
// fetch redirect pair and the EX/MEM outputs of the execute stage.
//
// Handshake: this bus has no valid/ready. The stage accepts one
// instruction every clock. Empty slots arrive as all-zero control
// (a bubble). The redirect pair is combinational. The M-stage fields
// are registered and appear one clock after the instruction is in EX.
//
// Modports:
//   master - the pipeline around the stage (drives E inputs, reads outputs)
//   slave  - the execute stage itself
interface execute_cycle_if #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
);
  logic                 RegWriteE;
  logic                 ALUSrcE;
  logic                 MemWriteE;
  logic [1:0]           ResultSrcE;
  logic                 BranchE;
  logic                 BranchTypeE;
  logic                 JumpE;
  logic [2:0]           ALUControlE;
  logic [XLEN-1:0]      RD1_E;
  logic [XLEN-1:0]      RD2_E;
  logic [XLEN-1:0]      Imm_Ext_E;
  logic [REGADDR_W-1:0] RD_E;
  logic [XLEN-1:0]      PCE;
  logic [XLEN-1:0]      PCPlus4E;
  logic [1:0]           ForwardA_E;
  logic [1:0]           ForwardB_E;
  logic [XLEN-1:0]      ResultW;

  logic                 PCSrcE;
  logic [XLEN-1:0]      PCTargetE;

  logic                 RegWriteM;
  logic                 MemWriteM;
  logic [1:0]           ResultSrcM;
  logic [REGADDR_W-1:0] RD_M;
  logic [XLEN-1:0]      ALUResultM;
  logic [XLEN-1:0]      WriteDataM;
  logic [XLEN-1:0]      PCPlus4M;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, BranchTypeE,
           JumpE, ALUControlE, RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
           ForwardA_E, ForwardB_E, ResultW,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, BranchTypeE,
           JumpE, ALUControlE, RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
           ForwardA_E, ForwardB_E, ResultW,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );
endinterface

// File: rtl/execute_cycle.sv
// execute_cycle: execute stage of the 5-stage RV32I pipeline.
// Applies operand forwarding, runs the ALU, resolves branches and jal
// (redirecting fetch in the same cycle) and registers results into EX/MEM.
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-low reset; clears EX/MEM and masks PCSrcE
//   bus - execute_cycle_if.slave: ID/EX inputs, ResultW forward source,
//         PCSrcE/PCTargetE redirect, EX/MEM registered outputs
module execute_cycle #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input logic           clk,
  input logic           rst,
  execute_cycle_if.slave bus
);

  logic [XLEN-1:0]      src_a;
  logic [XLEN-1:0]      fwd_b;
  logic [XLEN-1:0]      src_b;
  logic [XLEN-1:0]      alu_result;
  logic                 zero;

  logic                 reg_write_m;
  logic                 mem_write_m;
  logic [1:0]           result_src_m;
  logic [REGADDR_W-1:0] rd_m;
  logic [XLEN-1:0]      alu_result_m;
  logic [XLEN-1:0]      write_data_m;
  logic [XLEN-1:0]      pc_plus4_m;

  // Forward muxes. Code 11 is unused by the hazard unit and falls back to
  // the register-file value, same as 00.
  always_comb begin
    src_a = bus.RD1_E;
    case (bus.ForwardA_E)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = alu_result_m;
      default: src_a = bus.RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = bus.RD2_E;
    case (bus.ForwardB_E)
      2'b01:   fwd_b = bus.ResultW;
      2'b10:   fwd_b = alu_result_m;
      default: fwd_b = bus.RD2_E;
    endcase
  end

  assign src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;

  // ALU: wrap-around arithmetic, shifts use only the low five bits of SrcB.
  always_comb begin
    alu_result = '0;
    case (bus.ALUControlE)
      3'b000: alu_result = src_a + src_b;
      3'b001: alu_result = src_a + ~src_b + {{(XLEN-1){1'b0}}, 1'b1};
      3'b010: alu_result = src_a & src_b;
      3'b011: alu_result = src_a | src_b;
      3'b100: alu_result = src_a ^ src_b;
      3'b101: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110: alu_result = src_a << src_b[4:0];
      3'b111: alu_result = src_a >> src_b[4:0];
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // Redirect: target is always computed; the select is held low in reset
  // so fetch never jumps while the pipeline is being cleared. jal wins
  // over a branch in the same slot.
  assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;
  assign bus.PCSrcE    = rst & (bus.JumpE | (bus.BranchE & (zero ^ bus.BranchTypeE)));

  // EX/MEM register. Reset drops whatever is in EX, so no store or
  // write-back escapes from an instruction caught by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
      rd_m         <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
    end else begin
      reg_write_m  <= bus.RegWriteE;
      mem_write_m  <= bus.MemWriteE;
      result_src_m <= bus.ResultSrcE;
      rd_m         <= bus.RD_E;
      alu_result_m <= alu_result;
      write_data_m <= fwd_b;
      pc_plus4_m   <= bus.PCPlus4E;
    end
  end

  assign bus.RegWriteM  = reg_write_m;
  assign bus.MemWriteM  = mem_write_m;
  assign bus.ResultSrcM = result_src_m;
  assign bus.RD_M       = rd_m;
  assign bus.ALUResultM = alu_result_m;
  assign bus.WriteDataM = write_data_m;
  assign bus.PCPlus4M   = pc_plus4_m;

endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: bench for execute_cycle. Directed scenarios followed by
// random instructions; expected redirect and EX/MEM values come from a
// behavioural model and are queued, then popped by independent monitors.
module tb_execute_cycle;

  logic clk;
  logic rst;

  execute_cycle_if #(.XLEN(32), .REGADDR_W(5)) bus ();

  execute_cycle #(.XLEN(32), .REGADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- types ----------------
  typedef struct packed {
    logic        rst;
    logic        rw;
    logic        alusrc;
    logic        mw;
    logic [1:0]  rs;
    logic        br;
    logic        bt;
    logic        j;
    logic [2:0]  op;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] resw;
  } ex_in_t;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } m_t;

  localparam int MW = $bits(m_t);

  logic [MW-1:0] exp_q[$];
  logic [32:0]   rdr_q[$];

  int checks = 0;
  int errors = 0;

  // Model state: what the EX/MEM ALU result will hold after the next edge.
  logic [31:0] model_alu_m = 32'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] resw, input logic [31:0] alum);
    if (sel == 2'b01) return resw;
    if (sel == 2'b10) return alum;
    return rf;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input ex_in_t s);
    logic [31:0] a, fb, b, res;
    logic        taken;
    m_t          m;
    @(posedge clk);
    #2;
    rst             = s.rst;
    bus.RegWriteE   = s.rw;
    bus.ALUSrcE     = s.alusrc;
    bus.MemWriteE   = s.mw;
    bus.ResultSrcE  = s.rs;
    bus.BranchE     = s.br;
    bus.BranchTypeE = s.bt;
    bus.JumpE       = s.j;
    bus.ALUControlE = s.op;
    bus.RD1_E       = s.rd1;
    bus.RD2_E       = s.rd2;
    bus.Imm_Ext_E   = s.imm;
    bus.RD_E        = s.rd;
    bus.PCE         = s.pc;
    bus.PCPlus4E    = s.pc + 32'd4;
    bus.ForwardA_E  = s.fa;
    bus.ForwardB_E  = s.fb;
    bus.ResultW     = s.resw;

    a     = fwd_ref(s.fa, s.rd1, s.resw, model_alu_m);
    fb    = fwd_ref(s.fb, s.rd2, s.resw, model_alu_m);
    b     = s.alusrc ? s.imm : fb;
    res   = alu_ref(s.op, a, b);
    taken = s.rst && (s.j || (s.br && ((res == 0) != s.bt)));
    rdr_q.push_back({taken, s.pc + s.imm});

    if (s.rst) begin
      m.rw = s.rw; m.mw = s.mw; m.rs = s.rs; m.rd = s.rd;
      m.alu = res; m.wd = fb; m.pc4 = s.pc + 32'd4;
    end else begin
      m = '0;
    end
    exp_q.push_back(m);
    model_alu_m = m.alu;
  endtask

  function automatic ex_in_t blank();
    ex_in_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rdr_q.size() > 0) begin
      logic [32:0] e;
      e = rdr_q.pop_front();
      check("PCSrcE", {31'b0, bus.PCSrcE}, {31'b0, e[32]});
      check("PCTargetE", bus.PCTargetE, e[31:0]);
    end
  end

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      m_t e;
      e = m_t'(exp_q.pop_front());
      check("RegWriteM", {31'b0, bus.RegWriteM}, {31'b0, e.rw});
      check("MemWriteM", {31'b0, bus.MemWriteM}, {31'b0, e.mw});
      check("ResultSrcM", {30'b0, bus.ResultSrcM}, {30'b0, e.rs});
      check("RD_M", {27'b0, bus.RD_M}, {27'b0, e.rd});
      check("ALUResultM", bus.ALUResultM, e.alu);
      check("WriteDataM", bus.WriteDataM, e.wd);
      check("PCPlus4M", bus.PCPlus4M, e.pc4);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ex_in_t s;
    rst = 1'b0;
    bus.RegWriteE = 0; bus.ALUSrcE = 0; bus.MemWriteE = 0; bus.ResultSrcE = 0;
    bus.BranchE = 0; bus.BranchTypeE = 0; bus.JumpE = 0; bus.ALUControlE = 0;
    bus.RD1_E = 0; bus.RD2_E = 0; bus.Imm_Ext_E = 0; bus.RD_E = 0; bus.PCE = 0;
    bus.PCPlus4E = 0; bus.ForwardA_E = 0; bus.ForwardB_E = 0; bus.ResultW = 0;

    // Reset held with busy inputs, including a jump that must not redirect.
    for (int i = 0; i < 2; i++) begin
      s = blank(); s.rst = 0; s.rw = 1; s.mw = 1; s.j = 1; s.rs = 2'b11;
      s.rd1 = 32'h55; s.rd2 = 32'h66; s.imm = 32'h8; s.rd = 5'd9; s.pc = 32'h100;
      issue(s);
    end

    // addi x3, 5 + 7
    s = blank(); s.rw = 1; s.alusrc = 1; s.rd1 = 5; s.imm = 7; s.rd = 3; issue(s);

    // beq taken, then not taken
    s = blank(); s.br = 1; s.op = 3'b001; s.rd1 = 32'h10; s.rd2 = 32'h10;
    s.pc = 32'h20; s.imm = 32'hFFFF_FFF8; issue(s);
    s.rd2 = 32'h11; issue(s);
    // bne taken with unequal operands, not taken with equal
    s.bt = 1; issue(s);
    s.rd2 = 32'h10; issue(s);
    // jal, and jal together with a not-taken branch
    s = blank(); s.j = 1; s.pc = 32'h40; s.imm = 32'h100; s.rw = 1; s.rd = 1; issue(s);
    s.br = 1; s.op = 3'b001; s.rd1 = 1; s.rd2 = 1; s.bt = 1; issue(s);

    // Forwarding: produce 0x30, then consume it via code 10 plus ResultW via 01
    s = blank(); s.rw = 1; s.alusrc = 1; s.rd1 = 32'h30; s.rd = 4; issue(s);
    s = blank(); s.fa = 2'b10; s.fb = 2'b01; s.resw = 32'h4; s.mw = 1;
    s.rd1 = 32'hDEAD; s.rd2 = 32'hBEEF; issue(s);
    // Code 11 behaves as 00
    s = blank(); s.fa = 2'b11; s.fb = 2'b11; s.resw = 32'h999; s.rd1 = 32'h3;
    s.rd2 = 32'h4; s.mw = 1; issue(s);

    // ALU corners
    s = blank(); s.alusrc = 1; s.rd1 = 32'h7FFF_FFFF; s.imm = 1; issue(s);
    s = blank(); s.op = 3'b101; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 1; issue(s);
    s = blank(); s.op = 3'b111; s.rd1 = 32'h8000_0000; s.rd2 = 31; issue(s);
    s = blank(); s.op = 3'b110; s.rd1 = 32'h3; s.rd2 = 33; issue(s);

    // Store caught by a one-cycle reset, then normal flow resumes
    s = blank(); s.mw = 1; s.rw = 1; s.alusrc = 1; s.rd1 = 32'h200; s.imm = 8;
    s.rd2 = 32'hCAFE; s.rd = 7; s.rst = 0; issue(s);
    s.rst = 1; issue(s);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      s.rst    = ($urandom_range(0, 19) != 0);
      s.rw     = $urandom_range(0, 1);
      s.alusrc = $urandom_range(0, 1);
      s.mw     = $urandom_range(0, 1);
      s.rs     = 2'($urandom_range(0, 3));
      s.br     = $urandom_range(0, 1);
      s.bt     = $urandom_range(0, 1);
      s.j      = ($urandom_range(0, 4) == 0);
      s.op     = 3'($urandom_range(0, 7));
      s.rd1    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      s.rd2    = ($urandom_range(0, 2) == 0) ? s.rd1 : $urandom;
      s.imm    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
      s.rd     = 5'($urandom_range(0, 31));
      s.pc     = $urandom & 32'hFFFF_FFFC;
      s.fa     = 2'($urandom_range(0, 3));
      s.fb     = 2'($urandom_range(0, 3));
      s.resw   = ($urandom_range(0, 2) == 0) ? s.rd1 : $urandom;
      issue(s);
    end

    // Drain with a bounded wait
    for (int i = 0; i < 10 && (exp_q.size() > 0 || rdr_q.size() > 0); i++)
      @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || rdr_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size() + rdr_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipeline.
- Consumes ID/EX control and data, applies forwarding, runs the ALU and resolves branches/jumps.
- Drives the redirect pair PCSrcE/PCTargetE back into fetch_cycle in the same cycle.
- Registers results into the EX/MEM pipeline register feeding the memory stage.

Parameters:
- XLEN, 32, datapath width.
- REGADDR_W, 5, register index width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset (rst==0 resets on the next rising clk)
- RegWriteE  input  1  write-back enable
- ALUSrcE  input  1  0: SrcB=forwarded RD2, 1: SrcB=Imm_Ext_E
- MemWriteE  input  1  store enable
- ResultSrcE  input  2  write-back select, passed through
- BranchE  input  1  conditional branch
- BranchTypeE  input  1  0: beq, 1: bne
- JumpE  input  1  unconditional jal
- ALUControlE  input  3  ALU op
- RD1_E  input  XLEN  rs1 data
- RD2_E  input  XLEN  rs2 data
- Imm_Ext_E  input  XLEN  sign-extended immediate
- RD_E  input  REGADDR_W  destination register
- PCE  input  XLEN  instruction PC
- PCPlus4E  input  XLEN  PC+4
- ForwardA_E  input  2  00: RD1_E, 01: ResultW, 10: ALUResultM
- ForwardB_E  input  2  same encoding for rs2
- ResultW  input  XLEN  write-back value
- PCSrcE  output  1  redirect fetch (combinational)
- PCTargetE  output  XLEN  redirect target (combinational)
- RegWriteM  output  1  registered
- MemWriteM  output  1  registered
- ResultSrcM  output  2  registered
- RD_M  output  REGADDR_W  registered
- ALUResultM  output  XLEN  registered; also the forward source for code 10
- WriteDataM  output  XLEN  registered forwarded rs2
- PCPlus4M  output  XLEN  registered

Behaviour:
- Forward muxes:
  - SrcA = mux(ForwardA_E).
  - FwdB = mux(ForwardB_E).
  - Code 11 selects RD1_E/RD2_E, i.e. it behaves as 00.
  - SrcB = ALUSrcE ? Imm_Ext_E : FwdB.
- ALU (combinational, XLEN-bit, wrap-around, no overflow flag):
  - 000 add, 001 sub (SrcA + ~SrcB + 1), 010 and, 011 or, 100 xor.
  - 101 slt: signed compare; result 1 or 0.
  - 110 sll: shift amount SrcB[4:0].
  - 111 srl: logical, shift amount SrcB[4:0].
- ZeroE = (ALUResult == 0).
- PCTargetE = PCE + Imm_Ext_E, modulo 2^XLEN. It is always driven, even when PCSrcE is 0.
- PCSrcE = rst & (JumpE | (BranchE & (ZeroE ^ BranchTypeE))). It is forced to 0 while rst==0.
- Redirect latency: zero cycles, combinational into fetch_cycle's PC mux; fetch takes PCTargetE on the next clk edge.
- EX/MEM register, on each rising clk:
  - If rst==0: every registered output is set to 0.
  - Otherwise it loads RegWriteE, MemWriteE, ResultSrcE, RD_E, ALUResult, FwdB and PCPlus4E.
  - Latency EX to M is one cycle.
- Reset mid-operation: an instruction in EX when rst falls is dropped. Its EX/MEM result is 0 and MemWriteM/RegWriteM are 0, so no store or write-back is issued.
- The stage has no stall or flush inputs. Bubbles arrive as all-zero control from ID/EX. A zero-control bubble produces PCSrcE=0 and zero M-stage enables.
- Simultaneous JumpE and BranchE: jump wins; PCSrcE=1 regardless of ZeroE.

Test Plan:
- Hold rst=0 for 2 cycles with nonzero inputs -> PCSrcE=0; all M outputs 0. Release rst=1 with ALUControlE=000, RD1_E=5, ALUSrcE=1, Imm=7, RD_E=3, RegWriteE=1 -> next cycle ALUResultM=12, RD_M=3, RegWriteM=1.
- beq taken: BranchE=1, BranchTypeE=0, RD1_E=RD2_E=0x10, ALUControlE=001, PCE=0x20, Imm=0xFFFFFFF8 -> same cycle PCSrcE=1, PCTargetE=0x18. With RD2_E=0x11 -> PCSrcE=0.
- bne and jal: BranchTypeE=1 with unequal operands -> PCSrcE=1. JumpE=1, PCE=0x40, Imm=0x100 -> PCSrcE=1, PCTargetE=0x140, PCPlus4M=0x44 next cycle.
- Forwarding: ForwardA_E=10 while ALUResultM=0x30, ForwardB_E=01 with ResultW=0x4, ALUSrcE=0, op 000 -> ALUResult=0x34. MemWriteE=1 -> WriteDataM=0x4.
- ALU corners:
  - 0x7FFFFFFF+1 -> 0x80000000.
  - slt(-1,1) -> 1.
  - srl(0x80000000, 31) -> 1.
  - sll with SrcB=33 -> shift by 1.
- Reset mid-stream: a store with MemWriteE=1 is in EX and rst drops for one cycle -> MemWriteM=0 and ALUResultM=0 after that edge. Normal flow resumes on the next instruction.
